// File: rtl/fft_rd_pkg.sv
// ---------------------------------------------------------------------------
// fft_rd_pkg
// Shared definitions for the FFT result reader: readout FSM state encoding,
// row FIFO geometry and the row type (one word from each of the four banks).
// No ports; imported by the reader, its row FIFO and the bench.
// ---------------------------------------------------------------------------
package fft_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int NUM_BANKS  = 4;

  // Default sample width; the reader itself is parameterised on DATA_W and
  // builds its own row type of the same shape when DATA_W is overridden.
  localparam int SAMPLE_W = 16;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef sample_t [NUM_BANKS-1:0]    row_t;

endpackage

// File: rtl/fft_result_reader_if.sv
// ---------------------------------------------------------------------------
// fft_result_reader_if
// Bundles the control, FFT RAM read and output stream signals of the reader.
//   iSTART / iABORT      readout request pulse / synchronous abort
//   iSHIFT               output shift amount (only with FFT_RD_SHIFT_EN)
//   oADDR_RD             read address shared by the four RAM banks
//   iDATA_RE_0..3        bank read data, RD_LAT clocks after the address
//   oDATA/oINDEX/oLAST   streamed sample, its point index, final-sample flag
//   oVALID / iREADY      stream handshake
//   oBUSY / oDONE        readout in progress / one-cycle completion pulse
// Modports: slave = the reader, master = whoever drives and consumes it.
// ---------------------------------------------------------------------------
interface fft_result_reader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);

  logic                     iSTART;
  logic                     iABORT;
`ifdef FFT_RD_SHIFT_EN
  logic [3:0]               iSHIFT;
`endif
  logic [ADDR_W-1:0]        oADDR_RD;
  logic signed [DATA_W-1:0] iDATA_RE_0;
  logic signed [DATA_W-1:0] iDATA_RE_1;
  logic signed [DATA_W-1:0] iDATA_RE_2;
  logic signed [DATA_W-1:0] iDATA_RE_3;
  logic signed [DATA_W-1:0] oDATA;
  logic [ADDR_W+1:0]        oINDEX;
  logic                     oVALID;
  logic                     iREADY;
  logic                     oLAST;
  logic                     oBUSY;
  logic                     oDONE;

  modport slave (
`ifdef FFT_RD_SHIFT_EN
    input  iSHIFT,
`endif
    input  iSTART, iABORT, iDATA_RE_0, iDATA_RE_1, iDATA_RE_2, iDATA_RE_3, iREADY,
    output oADDR_RD, oDATA, oINDEX, oVALID, oLAST, oBUSY, oDONE
  );

  modport master (
`ifdef FFT_RD_SHIFT_EN
    output iSHIFT,
`endif
    output iSTART, iABORT, iDATA_RE_0, iDATA_RE_1, iDATA_RE_2, iDATA_RE_3, iREADY,
    input  oADDR_RD, oDATA, oINDEX, oVALID, oLAST, oBUSY, oDONE
  );

endinterface

// File: rtl/fft_rd_row_fifo.sv
// ---------------------------------------------------------------------------
// fft_rd_row_fifo
// FIFO_DEPTH-row synchronous FIFO holding complete bank rows.
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous flush (pointers and count to zero)
//   push/push_row  write one row
//   pop          drop the head row
//   head_row     current head (meaningful only while count != 0)
//   count        occupancy 0..FIFO_DEPTH
// The caller guarantees no push when full and no pop when empty.
// ---------------------------------------------------------------------------
module fft_rd_row_fifo
  import fft_rd_pkg::*;
#(
  parameter int ROW_W = $bits(row_t)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [ROW_W-1:0]      push_row,
  input  logic                  pop,
  output logic [ROW_W-1:0]      head_row,
  output logic [FIFO_CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [ROW_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: storage has no reset; only the pointers and count decide what is
  // valid, and the reader masks oDATA while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_row;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_row = mem[rd_ptr];

endmodule

// File: rtl/fft_result_reader.sv
// ---------------------------------------------------------------------------
// fft_result_reader
// Reads all four FFT RAM banks (2**ADDR_W words each) once per iSTART and
// streams the 4*2**ADDR_W samples in point order (index = 4*addr + bank).
//   iCLK, iRESET  clock, asynchronous active-low reset
//   bus           fft_result_reader_if.slave (control, RAM read, stream)
// Reads are only issued while the row FIFO plus the reads still in flight
// leave room for the returning row, so the FIFO cannot overflow however
// long the consumer stalls.
// Build option: define FFT_RD_SHIFT_EN to add iSHIFT; oDATA then becomes the
// sample arithmetically shifted right by iSHIFT (latched at iSTART) with
// round-half-up. Without it oDATA is the raw sample.
// ---------------------------------------------------------------------------
module fft_result_reader
  import fft_rd_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic iCLK,
  input  logic iRESET,
  fft_result_reader_if.slave bus
);

  localparam int OCC_W = $clog2(RD_LAT + FIFO_DEPTH + 1);

  typedef logic [NUM_BANKS-1:0][DATA_W-1:0] bank_row_t;

  rd_state_t                state;
  logic [ADDR_W-1:0]        rd_addr;
  logic                     busy;
  logic                     done;
  logic [RD_LAT-1:0]        inflight;
  logic [OCC_W-1:0]         inflight_cnt;
  logic [OCC_W-1:0]         occupancy;
  logic [FIFO_CNT_W-1:0]    fifo_count;
  bank_row_t                push_row;
  bank_row_t                head_row;
  logic [ADDR_W-1:0]        row_cnt;
  logic [1:0]               bank_cnt;
  logic                     issue;
  logic                     valid;
  logic                     xfer;
  logic                     pop;
  logic                     last;
  logic signed [DATA_W-1:0] sample;
  logic signed [DATA_W-1:0] shaped;
  logic                     start_ok;

  assign start_ok = (state == ST_IDLE) && bus.iSTART && !bus.iABORT;

  // -------------------------------------------------------------------------
  // Read issue: rows already buffered plus rows still in the RAM pipeline
  // must leave space for one more row.
  // -------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + OCC_W'(inflight[i]);
    end
  end

  assign occupancy = OCC_W'(fifo_count) + inflight_cnt;
  assign issue     = (state == ST_RUN) && (occupancy < OCC_W'(FIFO_DEPTH));

  // -------------------------------------------------------------------------
  // Readout FSM with registered address, busy and done.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state   <= ST_IDLE;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (bus.iABORT) begin
      state   <= ST_IDLE;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.iSTART) begin
            state   <= ST_RUN;
            rd_addr <= '0;
            busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (issue) begin
            // The final address is held rather than wrapped to 0.
            if (&rd_addr) state <= ST_DRAIN;
            else          rd_addr <= rd_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (xfer && last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          rd_addr <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // In-flight tracking: one bit per outstanding read, RD_LAT stages deep.
  // The last stage lines up with valid bank data.
  // -------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      inflight <= '0;
    end else if (bus.iABORT) begin
      inflight <= '0;
    end else begin
      inflight[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        inflight[i] <= inflight[i-1];
      end
    end
  end

  assign push_row = {bus.iDATA_RE_3, bus.iDATA_RE_2, bus.iDATA_RE_1, bus.iDATA_RE_0};

  fft_rd_row_fifo #(
    .ROW_W (NUM_BANKS * DATA_W)
  ) u_row_fifo (
    .clk      (iCLK),
    .rst_n    (iRESET),
    .clear    (bus.iABORT),
    .push     (inflight[RD_LAT-1]),
    .push_row (push_row),
    .pop      (pop),
    .head_row (head_row),
    .count    (fifo_count)
  );

  // -------------------------------------------------------------------------
  // Output stream: the bank counter walks the head row, which is popped
  // after its last word. Row and bank counters together form the index.
  // -------------------------------------------------------------------------
  assign valid = (fifo_count != '0);
  assign xfer  = valid && bus.iREADY;
  assign pop   = xfer && (bank_cnt == 2'd3);
  assign last  = valid && (&{row_cnt, bank_cnt});

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      row_cnt  <= '0;
      bank_cnt <= '0;
    end else if (bus.iABORT || start_ok) begin
      row_cnt  <= '0;
      bank_cnt <= '0;
    end else if (xfer) begin
      bank_cnt <= bank_cnt + 1'b1;
      if (bank_cnt == 2'd3) row_cnt <= row_cnt + 1'b1;
    end
  end

  assign sample = head_row[bank_cnt];

`ifdef FFT_RD_SHIFT_EN
  logic [3:0]               shift_q;
  logic signed [DATA_W:0]   wide;
  logic signed [DATA_W:0]   round_bit;

  // Shift amount is frozen for the whole readout.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET)       shift_q <= '0;
    else if (start_ok) shift_q <= bus.iSHIFT;
  end

  // One guard bit keeps the rounding add from overflowing at full scale.
  always_comb begin
    wide      = (DATA_W+1)'(sample);
    round_bit = '0;
    shaped    = sample;
    if (shift_q != 4'd0) begin
      round_bit = (DATA_W+1)'(1) << (shift_q - 4'd1);
      shaped    = DATA_W'((wide + round_bit) >>> shift_q);
    end
  end
`else
  assign shaped = sample;
`endif

  assign bus.oADDR_RD = rd_addr;
  assign bus.oDATA    = valid ? shaped : '0;
  assign bus.oINDEX   = {row_cnt, bank_cnt};
  assign bus.oVALID   = valid;
  assign bus.oLAST    = last;
  assign bus.oBUSY    = busy;
  assign bus.oDONE    = done;

endmodule

// File: tb/tb_fft_result_reader.sv
// ---------------------------------------------------------------------------
// tb_fft_result_reader
// Bench for fft_result_reader: a behavioural RD_LAT-cycle RAM model per bank,
// a scoreboard queue filled at iSTART and drained by a negedge monitor, a
// table of readout scenarios, and hand-written corner sequences.
// ---------------------------------------------------------------------------
module tb_fft_result_reader;
  import fft_rd_pkg::*;

  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 16;
  localparam int RD_LAT   = 2;
  localparam int N_WORDS  = 2 ** ADDR_W;
  localparam int N_POINTS = NUM_BANKS * N_WORDS;
  localparam int BUDGET   = 12000;

  logic iCLK = 1'b0;
  logic iRESET;

  always #5 iCLK = ~iCLK;

  fft_result_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fft_result_reader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .bus    (bus)
  );

  // ---------------- RAM model ----------------
  logic signed [DATA_W-1:0] mem [NUM_BANKS][N_WORDS];
  row_t ram_pipe [RD_LAT];

  always @(posedge iCLK) begin
    for (int b = 0; b < NUM_BANKS; b++) ram_pipe[0][b] <= mem[b][bus.oADDR_RD];
    for (int s = 1; s < RD_LAT; s++) ram_pipe[s] <= ram_pipe[s-1];
  end

  assign bus.iDATA_RE_0 = ram_pipe[RD_LAT-1][0];
  assign bus.iDATA_RE_1 = ram_pipe[RD_LAT-1][1];
  assign bus.iDATA_RE_2 = ram_pipe[RD_LAT-1][2];
  assign bus.iDATA_RE_3 = ram_pipe[RD_LAT-1][3];

  // ---------------- bookkeeping ----------------
  typedef struct {
    int data;
    int index;
    bit last;
  } exp_t;

  typedef struct {
    string name;
    int    ready_pct;
    int    abort_at;
    int    reset_at;
    bit    start_in_run;
    int    exp_xfers;
    int    exp_done;
  } scen_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_cyc = -10;
  int shift_val = 0;
  int got_data [4];
  bit hold = 1'b0;
  logic signed [DATA_W-1:0] h_data;
  logic [ADDR_W+1:0] h_index;
  logic h_last;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  function automatic int exp_word(input int idx);
    int w;
    w = int'(mem[idx % NUM_BANKS][idx / NUM_BANKS]);
    if (shift_val != 0) w = (w + (1 << (shift_val - 1))) >>> shift_val;
    return w;
  endfunction

  task automatic push_expectations();
    exp_q.delete();
    for (int i = 0; i < N_POINTS; i++) exp_q.push_back('{exp_word(i), i, (i == N_POINTS - 1)});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"},  bus.oADDR_RD, 0);
    check({tag, "_data"},  $signed(bus.oDATA), 0);
    check({tag, "_index"}, bus.oINDEX, 0);
    check({tag, "_valid"}, bus.oVALID, 0);
    check({tag, "_last"},  bus.oLAST, 0);
    check({tag, "_busy"},  bus.oBUSY, 0);
    check({tag, "_done"},  bus.oDONE, 0);
  endtask

  // ---------------- monitor (samples mid-cycle) ----------------
  always @(negedge iCLK) begin
    exp_t e;
    cyc++;
    if (iRESET !== 1'b1) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("stall_valid", bus.oVALID, 1);
        check("stall_data",  $signed(bus.oDATA), $signed(h_data));
        check("stall_index", bus.oINDEX, h_index);
        check("stall_last",  bus.oLAST, h_last);
      end
      if (bus.oBUSY)
        check("reads_ahead_of_space",
              (int'(bus.oADDR_RD) <= xfer_cnt / NUM_BANKS + FIFO_DEPTH) ? 1 : 0, 1);
      if (bus.oDONE) begin
        done_cnt++;
        check("done_after_last", cyc, last_cyc + 1);
      end
      if (bus.oVALID && bus.iREADY) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", bus.oINDEX, -1);
        end else begin
          e = exp_q.pop_front();
          check("xfer_data",  $signed(bus.oDATA), e.data);
          check("xfer_index", bus.oINDEX, e.index);
          check("xfer_last",  bus.oLAST, e.last);
        end
        if (bus.oINDEX < 4) got_data[bus.oINDEX] = int'($signed(bus.oDATA));
        if (bus.oLAST) last_cyc = cyc;
        xfer_cnt++;
      end
      hold    = bus.oVALID && !bus.iREADY && !bus.iABORT;
      h_data  = bus.oDATA;
      h_index = bus.oINDEX;
      h_last  = bus.oLAST;
    end
  end

  // ---------------- scenario runner ----------------
  task automatic run_case(input scen_t s);
    int cycles;
    bit ended;
    cycles = 0;
    ended  = 1'b0;
    xfer_cnt = 0;
    done_cnt = 0;
    push_expectations();
    bus.iREADY = ($urandom_range(0, 99) < s.ready_pct);
    bus.iSTART = 1'b1;
    tick();
    bus.iSTART = 1'b0;
    while (!ended && cycles < BUDGET) begin
      bus.iREADY = ($urandom_range(0, 99) < s.ready_pct);
      bus.iSTART = s.start_in_run && (cycles == 20);
      if (s.abort_at >= 0 && xfer_cnt >= s.abort_at) begin
        bus.iABORT = 1'b1;
        bus.iREADY = 1'b0;
        tick();
        bus.iABORT = 1'b0;
        check($sformatf("%s_valid_after_abort", s.name), bus.oVALID, 0);
        check($sformatf("%s_busy_after_abort", s.name), bus.oBUSY, 0);
        repeat (20) tick();
        ended = 1'b1;
      end else if (s.reset_at >= 0 && xfer_cnt >= s.reset_at) begin
        iRESET = 1'b0;
        #1;
        check_reset_values(s.name);
        tick();
        iRESET = 1'b1;
        tick();
        ended = 1'b1;
      end else begin
        tick();
        cycles++;
        if (done_cnt != 0) ended = 1'b1;
      end
    end
    bus.iSTART = 1'b0;
    bus.iREADY = 1'b1;
    repeat (3) tick();
    check($sformatf("%s_finished_in_budget", s.name), ended, 1);
    check($sformatf("%s_xfers", s.name), xfer_cnt, s.exp_xfers);
    check($sformatf("%s_done_pulses", s.name), done_cnt, s.exp_done);
    check($sformatf("%s_busy_idle", s.name), bus.oBUSY, 0);
    if (s.exp_xfers == N_POINTS) check($sformatf("%s_left_in_queue", s.name), exp_q.size(), 0);
  endtask

  scen_t scen [7];

  initial begin
    int k;
    int budget;

    scen[0] = '{"full_ready",    100,  -1,   -1, 1'b0, N_POINTS, 1};
    scen[1] = '{"random_50",      50,  -1,   -1, 1'b0, N_POINTS, 1};
    scen[2] = '{"abort_700",     100, 700,   -1, 1'b0, 700,      0};
    scen[3] = '{"restart",       100,  -1,   -1, 1'b0, N_POINTS, 1};
    scen[4] = '{"reset_1000",     70,  -1, 1000, 1'b0, 1000,     0};
    scen[5] = '{"start_in_run",  100,  -1,   -1, 1'b1, N_POINTS, 1};
    scen[6] = '{"random_30",      30,  -1,   -1, 1'b0, N_POINTS, 1};

    for (int b = 0; b < NUM_BANKS; b++)
      for (int a = 0; a < N_WORDS; a++)
        mem[b][a] = DATA_W'(NUM_BANKS * a + b);

    iRESET     = 1'b0;
    bus.iSTART = 1'b0;
    bus.iABORT = 1'b0;
    bus.iREADY = 1'b0;
`ifdef FFT_RD_SHIFT_EN
    bus.iSHIFT = 4'd0;
`endif

    // Reset state.
    repeat (2) @(posedge iCLK);
    #1;
    check_reset_values("reset");
    iRESET = 1'b1;
    tick();

    // First-valid latency, sustained rate, then abort and start together.
    xfer_cnt = 0;
    push_expectations();
    bus.iREADY = 1'b1;
    bus.iSTART = 1'b1;
    tick();
    bus.iSTART = 1'b0;
    check("busy_after_start", bus.oBUSY, 1);
    k = 0;
    budget = 0;
    while (!bus.oVALID && budget < 20) begin
      tick();
      budget++;
    end
    k = budget;
    check("first_valid_latency", k, RD_LAT + 1);
    check("first_valid_index", bus.oINDEX, 0);
    repeat (64) tick();
    check("sustained_rate", xfer_cnt, 64);
    bus.iABORT = 1'b1;
    bus.iSTART = 1'b1;
    bus.iREADY = 1'b0;
    tick();
    bus.iABORT = 1'b0;
    bus.iSTART = 1'b0;
    check("abort_start_valid", bus.oVALID, 0);
    check("abort_start_busy", bus.oBUSY, 0);
    repeat (3) tick();
    check("abort_start_stays_idle", bus.oBUSY, 0);
    check("abort_start_no_valid", bus.oVALID, 0);
    check("abort_start_addr", bus.oADDR_RD, 0);

    // Table of readout scenarios.
    for (int i = 0; i < 7; i++) run_case(scen[i]);

`ifdef FFT_RD_SHIFT_EN
    // Rounded shift on hand-picked words, latched at iSTART.
    mem[0][0] = 16'sd7;
    mem[1][0] = -16'sd7;
    mem[2][0] = 16'sd32767;
    shift_val  = 2;
    bus.iSHIFT = 4'd2;
    run_case(scen[0]);
    check("shift_pos7",  got_data[0], 2);
    check("shift_neg7",  got_data[1], -2);
    check("shift_max",   got_data[2], 8192);
    shift_val  = 0;
    bus.iSHIFT = 4'd0;
    mem[0][0] = 16'sd0;
    mem[1][0] = 16'sd1;
    mem[2][0] = 16'sd2;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_result_reader.md
FFT_RESULT_READER -- requirements
Module: fft_result_reader

Interface
REQ-001 Parameter ADDR_W, default 9, meaning per-bank RAM address width (512 words/bank).
REQ-002 Parameter DATA_W, default 16, meaning signed sample width.
REQ-003 Parameter RD_LAT, default 2, meaning fixed FFT RAM read latency in clocks, address to data.
REQ-004 iCLK  input  1  sole clock, all logic on rising edge.
REQ-005 iRESET  input  1  asynchronous, active-low reset.
REQ-006 iSTART  input  1  one-cycle pulse requesting readout of all FFT RAM contents.
REQ-007 iABORT  input  1  synchronous abort of readout in progress.
REQ-008 oADDR_RD  output  ADDR_W  read address driven to all four FFT RAM banks (iADDR_RD_0..3).
REQ-009 iDATA_RE_0..3  input  DATA_W each  FFT bank read data (oDATA_RE_0..3), valid RD_LAT cycles after address.
REQ-010 oDATA  output  DATA_W  streamed signed sample.
REQ-011 oINDEX  output  ADDR_W+2  point index of oDATA = 4*addr + bank.
REQ-012 oVALID / iREADY  output / input  1 each  stream handshake; transfer when both high.
REQ-013 oLAST  output  1  high with oVALID on index 2047.
REQ-014 oBUSY  output  1  high in RUN or DRAIN.
REQ-015 oDONE  output  1  one-cycle pulse after last transfer.

Function
REQ-016 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on iSTART; RUN->DRAIN after read of addr 511 issued; DRAIN->DONE on oLAST transfer; DONE->IDLE next cycle.
REQ-017 iSTART outside IDLE ignored; iABORT in any state -> IDLE next cycle, FIFO, in-flight reads and counters cleared, no oDONE; iABORT with iSTART same cycle: abort wins.
REQ-018 Read issue in RUN only when (FIFO occupancy + reads in flight) < 4; oADDR_RD increments by 1 per issued read, 0 to 511, no wrap.
REQ-019 In-flight tracking: RD_LAT-deep valid shift register; on its output the four bank words are written as one row into a 4-row FIFO; overflow impossible by REQ-018.
REQ-020 oVALID = FIFO non-empty; oDATA selects bank word by 2-bit bank counter; counter advances on transfer, row popped after bank 3 transfer.
REQ-021 oDATA/oINDEX/oLAST held stable while oVALID & !iREADY.
REQ-022 With iREADY constantly high, sustained throughput 1 sample/clock; first oVALID exactly RD_LAT+1 cycles after iSTART.
REQ-023 Exactly 2048 transfers per completed readout, indices 0..2047 strictly increasing.

Reset
REQ-024 iRESET low: state IDLE, oADDR_RD=0, oDATA=0, oINDEX=0, oVALID=0, oLAST=0, oBUSY=0, oDONE=0, FIFO empty, in-flight cleared; mid-readout reset discards everything.

Configuration
REQ-025 Macro FFT_RD_SHIFT_EN: when defined, adds input iSHIFT (4 bits) and oDATA = arithmetic right shift of sample by iSHIFT with round-half-up (add 1<<(iSHIFT-1) before shift; iSHIFT=0 passthrough), iSHIFT sampled at iSTART; undefined: no port, oDATA = raw sample.

Structure
REQ-026 Shared package fft_rd_pkg: FSM state enum, FIFO depth constant (4), bank count constant (4), row typedef (4 x DATA_W).
REQ-027 One sub-module fft_rd_row_fifo (4-row synchronous FIFO, push/pop/count); remainder in fft_result_reader.

Verification
REQ-028 Banks preloaded with word = 4*addr+bank, iREADY=1, iSTART -> 2048 transfers, oDATA==oINDEX each, oLAST at 2047, oDONE one cycle later.
REQ-029 Random iREADY 50% -> same sequence, no loss/duplication, data stable during stalls, reads in flight never exceed FIFO space.
REQ-030 iABORT at transfer 700 -> oVALID=0 next cycle, oBUSY=0, no oDONE; new iSTART restarts from index 0.
REQ-031 iRESET low at transfer 1000 -> all outputs reset values immediately; iSTART during RUN ignored (no restart, count stays 2048).
REQ-032 FFT_RD_SHIFT_EN, iSHIFT=2, word 7 -> oDATA 2; word -7 -> -2; word 32767 -> 8192.
